// File: rtl/dma_rd_pkg.sv
// Shared types and widths for the DMA read client and its beat FIFO.
package dma_rd_pkg;

  localparam int DMA_ADDR_W = 27;
  localparam int DMA_DATA_W = 512;
  localparam int DMA_CH_NUM = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SPACE,
    ST_REQ,
    ST_DATA
  } rd_state_e;

  function automatic logic [DMA_ADDR_W-1:0] burst_len(
    input logic [DMA_ADDR_W-1:0] remain,
    input int unsigned           max_burst
  );
    if (remain > DMA_ADDR_W'(max_burst)) return DMA_ADDR_W'(max_burst);
    return remain;
  endfunction

endpackage

// File: rtl/dma_rd_fifo.sv
// First-word-fall-through beat buffer; a write becomes visible on o_vld the next cycle.
// o_free reports empty entries so the requester can reserve a whole burst up front.
module dma_rd_fifo #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 513
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_wr_en,
  input  logic [WIDTH-1:0]           i_wr_dat,
  input  logic                       i_rd_en,
  output logic [WIDTH-1:0]           o_rd_dat,
  output logic                       o_vld,
  output logic [$clog2(DEPTH):0]     o_free
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_wr_en && (r_count != (AW+1)'(DEPTH));
  assign w_pop  = i_rd_en && (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  assign o_rd_dat = r_mem[r_rd_ptr];
  assign o_vld    = (r_count != '0);
  assign o_free   = (AW+1)'(DEPTH) - r_count;

endmodule

// File: rtl/dma_read_client.sv
// Per-channel DDR3 DMA read requester: splits commands into MAX_BURST bursts and re-streams beats.
// Optional beat-count check on each burst enabled by DMA_RD_CLIENT_LEN_CHECK_EN.
module dma_read_client
  import dma_rd_pkg::*;
#(
  parameter int CH         = 0,
  parameter int MAX_BURST  = 64,
  parameter int FIFO_DEPTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  input  logic [DMA_ADDR_W-1:0] cmd_addr,
  input  logic [DMA_ADDR_W-1:0] cmd_len,
  output logic                  cmd_ready,
  output logic                  read_req,
  output logic [DMA_ADDR_W-1:0] read_start_addr,
  output logic [DMA_ADDR_W-1:0] read_length,
  input  logic                  read_ack,
  input  logic [DMA_DATA_W-1:0] dout,
  input  logic [DMA_CH_NUM-1:0] dout_en,
  input  logic                  dout_eop,
  output logic [DMA_DATA_W-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  err_len
);

  rd_state_e r_state;
  rd_state_e w_state_nxt;

  logic [DMA_ADDR_W-1:0] r_addr;
  logic [DMA_ADDR_W-1:0] r_remain;
  logic [DMA_ADDR_W-1:0] r_req_addr;
  logic [DMA_ADDR_W-1:0] r_req_len;

  logic [DMA_ADDR_W-1:0]         w_burst;
  logic [$clog2(FIFO_DEPTH):0]   w_free;
  logic                          w_space_ok;
  logic                          w_accept;
  logic                          w_ack;
  logic                          w_beat;
  logic                          w_last;
  logic [DMA_DATA_W:0]           w_fifo_dat;
  logic                          w_unused_en;

  assign w_burst    = burst_len(r_remain, MAX_BURST);
  assign w_space_ok = DMA_ADDR_W'(w_free) >= w_burst;
  assign w_accept   = (r_state == ST_IDLE) && cmd_valid && (cmd_len != '0);
  assign w_ack      = (r_state == ST_REQ) && read_ack;
  assign w_beat     = (r_state == ST_DATA) && dout_en[CH];
  assign w_last     = dout_eop && (r_remain == '0);
  assign w_unused_en = ^dout_en;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:       if (w_accept) w_state_nxt = ST_WAIT_SPACE;
      ST_WAIT_SPACE: if (w_space_ok) w_state_nxt = ST_REQ;
      ST_REQ:        if (read_ack) w_state_nxt = ST_DATA;
      ST_DATA: begin
        if (w_beat && dout_eop)
          w_state_nxt = (r_remain != '0) ? ST_WAIT_SPACE : ST_IDLE;
      end
      default:       w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_remain   <= '0;
      r_req_addr <= '0;
      r_req_len  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr   <= cmd_addr;
        r_remain <= cmd_len;
      end
      // Request fields freeze here so they stay stable for the whole REQ phase.
      if ((r_state == ST_WAIT_SPACE) && w_space_ok) begin
        r_req_addr <= r_addr;
        r_req_len  <= w_burst;
      end
      if (w_ack) begin
        r_addr   <= r_addr + r_req_len;
        r_remain <= r_remain - r_req_len;
      end
    end
  end

  assign cmd_ready       = (r_state == ST_IDLE);
  assign read_req        = (r_state == ST_REQ);
  assign busy            = (r_state != ST_IDLE);
  assign read_start_addr = r_req_addr;
  assign read_length     = r_req_len;

  assign w_fifo_dat = {w_last, dout};

  dma_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DMA_DATA_W + 1)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_wr_en  (w_beat),
    .i_wr_dat (w_fifo_dat),
    .i_rd_en  (out_ready),
    .o_rd_dat ({out_last, out_data}),
    .o_vld    (out_valid),
    .o_free   (w_free)
  );

`ifdef DMA_RD_CLIENT_LEN_CHECK_EN
  logic [DMA_ADDR_W-1:0] r_beat_cnt;
  logic                  r_err_len;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt <= '0;
      r_err_len  <= 1'b0;
    end else begin
      if (w_ack)       r_beat_cnt <= '0;
      else if (w_beat) r_beat_cnt <= r_beat_cnt + DMA_ADDR_W'(1);
      // Flag an overrun beat or an eop that closes the burst early/late.
      if (w_beat && ((r_beat_cnt == r_req_len) ||
                     (dout_eop && ((r_beat_cnt + DMA_ADDR_W'(1)) != r_req_len))))
        r_err_len <= 1'b1;
    end
  end

  assign err_len = r_err_len;
`else
  assign err_len = 1'b0;
`endif

endmodule

// File: tb/tb_dma_read_client.sv
// Bench for dma_read_client: engine model, random consumer, queue-based reference of bursts and beats.
`timescale 1ns/1ps
module tb_dma_read_client;
  import dma_rd_pkg::*;

  localparam int CH = 3;
  localparam int MB = 64;
  localparam int FD = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [26:0] cmd_addr, cmd_len;
  logic        cmd_ready, read_req, read_ack;
  logic [26:0] read_start_addr, read_length;
  logic [511:0] dout, out_data;
  logic [15:0] dout_en;
  logic        dout_eop, out_valid, out_ready, out_last, busy, err_len;

  always #5 clk = ~clk;

  dma_read_client #(.CH(CH), .MAX_BURST(MB), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_ready(cmd_ready), .read_req(read_req), .read_start_addr(read_start_addr),
    .read_length(read_length), .read_ack(read_ack), .dout(dout), .dout_en(dout_en),
    .dout_eop(dout_eop), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .err_len(err_len)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct packed { logic [511:0] dat; logic last; } beat_t;
  typedef struct packed { logic [26:0] addr; logic [26:0] len; } req_t;

  beat_t exp_q[$];
  req_t  exp_req_q[$];

  function automatic logic [511:0] beat_data(input logic [26:0] a);
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = {k[4:0], a};
    return d;
  endfunction

  // Reference: every beat of the command in address order, and the burst split.
  task automatic model_cmd(input logic [26:0] a, input logic [26:0] l);
    logic [26:0] ra, rr, b;
    for (int i = 0; i < int'(l); i++) exp_q.push_back({beat_data(a + 27'(i)), (i == int'(l) - 1)});
    ra = a; rr = l;
    while (rr != 0) begin
      b = (rr > 27'(MB)) ? 27'(MB) : rr;
      exp_req_q.push_back({ra, b});
      ra = ra + b;
      rr = rr - b;
    end
  endtask

  logic eng_kill = 1'b0;
  int   eng_short = 0;
  int   req_seen = 0;
  int   wr_cnt = 0;
  int   rd_cnt = 0;
  int   occ_base = 0;
  int   beats_seen = 0;

  // Engine model: ack after a random delay, then stream beats with other-channel noise mixed in.
  initial begin : engine
    req_t got, e;
    int   nb;
    read_ack = 1'b0; dout = '0; dout_en = '0; dout_eop = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (read_req && !rst && !eng_kill) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        got = {read_start_addr, read_length};
        read_ack = 1'b1;
        req_seen++;
        if (exp_req_q.size() == 0) check("req_extra", 1, 0);
        else begin
          e = exp_req_q.pop_front();
          check("req_addr", got.addr, e.addr);
          check("req_len", got.len, e.len);
        end
        @(posedge clk); #1;
        check("req_drop", read_req, 0);
        read_ack = 1'b0;
        nb = (eng_short > 0) ? eng_short : int'(got.len);
        for (int i = 0; i < nb && !eng_kill; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            dout_en  = 16'($urandom) & ~16'h0008;
            dout     = {16{$urandom}};
            dout_eop = 1'($urandom);
            @(posedge clk); #1;
          end
          if (!eng_kill) begin
            check("fifo_room", (wr_cnt - rd_cnt - occ_base) < FD, 1);
            dout_en  = (16'($urandom) & ~16'h0008) | 16'h0008;
            dout     = beat_data(got.addr + 27'(i));
            dout_eop = (i == nb - 1);
            wr_cnt++;
            @(posedge clk); #1;
          end
        end
        dout_en = '0; dout_eop = 1'b0;
      end
    end
  end

  int   rdy_mode = 0;
  logic man_rdy = 1'b0;

  initial begin : consumer
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom);
        default: out_ready = man_rdy;
      endcase
    end
  end

  always @(negedge clk) begin : monitor
    beat_t e;
    if (!rst && out_valid && out_ready) begin
      rd_cnt++;
      beats_seen++;
      if (exp_q.size() == 0) check("beat_extra", 1, 0);
      else begin
        e = exp_q.pop_front();
        n_checks++;
        if (out_data === e.dat) n_pass++;
        else $display("FAIL beat_dat: got 0x%0h, expected 0x%0h", out_data[63:0], e.dat[63:0]);
        check("beat_last", out_last, e.last);
      end
    end
  end

  task automatic send_cmd(input logic [26:0] a, input logic [26:0] l);
    int t = 0;
    @(posedge clk); #1;
    while (!cmd_ready && t < 1000) begin @(posedge clk); #1; t++; end
    model_cmd(a, l);
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 5000) begin @(posedge clk); #1; t++; end
    check({name, "_timeout"}, t < 5000, 1);
  endtask

  typedef struct {
    logic [26:0] addr;
    logic [26:0] len;
    int          rmode;
    int          exp_reqs;
    int          exp_beats;
  } vec_t;

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    vec_t vecs[5];
    int   rq0, b0, t, w0;
    logic saw;
    logic [26:0] ra, rl;

    vecs[0] = '{27'h100,     27'd4,   0, 1, 4};
    vecs[1] = '{27'h0,       27'd150, 0, 3, 150};
    vecs[2] = '{27'h7FFFFF0, 27'd80,  1, 2, 80};
    vecs[3] = '{27'h200,     27'd64,  1, 1, 64};
    vecs[4] = '{27'h300,     27'd65,  1, 2, 65};

    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_read_req", read_req, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err_len", err_len, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_start_addr", read_start_addr, 0);
    check("rst_length", read_length, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      rdy_mode = vecs[i].rmode;
      rq0 = req_seen; b0 = beats_seen;
      send_cmd(vecs[i].addr, vecs[i].len);
      check("t1_wait_space", {busy, read_req}, 2'b10);
      @(posedge clk); #1;
      check("t2_read_req", read_req, 1);
      check("t2_addr", read_start_addr, vecs[i].addr);
      check("t2_len", read_length, (vecs[i].len > 27'(MB)) ? 27'(MB) : vecs[i].len);
      wait_done("vec");
      check("vec_reqs", req_seen - rq0, vecs[i].exp_reqs);
      check("vec_beats", beats_seen - b0, vecs[i].exp_beats);
    end

    for (int i = 0; i < 6; i++) begin
      rdy_mode = 1;
      ra = 27'($urandom);
      rl = 27'($urandom_range(1, 300));
      rq0 = req_seen; b0 = beats_seen;
      send_cmd(ra, rl);
      wait_done("rand");
      check("rand_reqs", req_seen - rq0, (int'(rl) + MB - 1) / MB);
      check("rand_beats", beats_seen - b0, int'(rl));
    end

    // Zero-length command is dropped outright.
    rdy_mode = 0;
    rq0 = req_seen;
    send_cmd(27'h55, 27'd0);
    check("len0_cmd_ready", cmd_ready, 1);
    check("len0_busy", busy, 0);
    saw = 1'b0;
    repeat (10) begin @(posedge clk); #1; if (read_req) saw = 1'b1; end
    check("len0_no_req", saw, 0);

    // Backpressure: third burst waits until a full burst of space is free.
    rdy_mode = 2; man_rdy = 1'b0;
    rq0 = req_seen; b0 = beats_seen;
    send_cmd(27'h1000, 27'd200);
    t = 0;
    while ((wr_cnt - rd_cnt - occ_base) != FD && t < 600) begin @(posedge clk); #1; t++; end
    repeat (10) begin @(posedge clk); #1; end
    check("bp_fill", wr_cnt - rd_cnt - occ_base, FD);
    check("bp_two_reqs", req_seen - rq0, 2);
    check("bp_req_held", read_req, 0);
    man_rdy = 1'b1;
    repeat (63) @(posedge clk);
    #1 man_rdy = 1'b0;
    saw = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (read_req) saw = 1'b1; end
    check("bp_63_no_req", saw, 0);
    check("bp_63_drained", beats_seen - b0, 63);
    man_rdy = 1'b1;
    @(posedge clk); #1;
    man_rdy = 1'b0;
    t = 0;
    while (!read_req && t < 8) begin @(posedge clk); #1; t++; end
    check("bp_64_req", read_req, 1);
    rdy_mode = 0;
    wait_done("bp");
    check("bp_reqs", req_seen - rq0, 4);
    check("bp_beats", beats_seen - b0, 200);

    // Reset in the middle of a burst.
    rdy_mode = 0;
    w0 = wr_cnt;
    send_cmd(27'h2000, 27'd64);
    t = 0;
    while ((wr_cnt - w0) < 10 && t < 300) begin @(posedge clk); #3; t++; end
    check("mid_reached", (wr_cnt - w0) >= 10, 1);
    rst = 1'b1; eng_kill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_out_valid", out_valid, 0);
    check("mid_read_req", read_req, 0);
    check("mid_cmd_ready", cmd_ready, 1);
    check("mid_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    exp_req_q.delete();
    repeat (3) begin @(posedge clk); #1; end
    occ_base = wr_cnt - rd_cnt;
    eng_kill = 1'b0;
    b0 = beats_seen;
    send_cmd(27'h300, 27'd5);
    wait_done("post_rst");
    check("post_rst_beats", beats_seen - b0, 5);

`ifdef DMA_RD_CLIENT_LEN_CHECK_EN
    // Engine closes a 4-beat burst after 3 beats.
    eng_short = 3;
    send_cmd(27'h400, 27'd4);
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back({beat_data(27'h400 + 27'(i)), (i == 2)});
    wait_done("short");
    eng_short = 0;
    check("err_len_set", err_len, 1);
    repeat (20) @(posedge clk);
    send_cmd(27'h500, 27'd3);
    wait_done("after_err");
    check("err_len_sticky", err_len, 1);
`else
    check("err_len_tied", err_len, 0);
`endif

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
